// File: rtl/cardinal_router_lport.sv
// Local port of a cardinal router: one flit per VC in each direction, with the
// link side and the core side working on opposite VCs in every cycle.
module cardinal_router_lport #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             polarity,
  input  logic             rx_si,
  output logic             rx_ri,
  input  logic [63:0]      rx_di,
  output logic             tx_so,
  input  logic             tx_ro,
  output logic [63:0]      tx_do,
  output logic             core_so,
  input  logic             core_ro,
  output logic [63:0]      core_do,
  input  logic             core_si,
  output logic             core_ri,
  input  logic [63:0]      core_di,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] tx_count
);

  logic        lv;
  logic        cv;
  logic [63:0] rx_data [2];
  logic [63:0] tx_data [2];
  logic [1:0]  rx_full;
  logic [1:0]  tx_full;
  logic        rx_take;
  logic        core_take;
  logic        core_put;
  logic [CNT_W-1:0] rx_count_reg;
  logic [CNT_W-1:0] tx_count_reg;

  assign lv = ~polarity;
  assign cv = polarity;

  assign rx_ri     = ~reset & ~rx_full[lv];
  assign rx_take   = rx_si & rx_ri;
  assign core_so   = ~reset & rx_full[cv];
  assign core_do   = rx_data[cv];
  assign core_take = core_so & core_ro;

  assign core_ri   = ~reset & ~tx_full[cv];
  assign core_put  = core_si & core_ri;
  assign tx_so     = ~reset & tx_full[lv] & tx_ro;
  assign tx_do     = tx_so ? tx_data[lv] : 64'h0;

  // Per-VC buffers: link and core never select the same VC in one cycle,
  // so set and clear of a full bit can never collide.
  for (genvar gi = 0; gi < 2; gi++) begin : g_vc
    localparam logic VC = 1'(gi);
    logic        rx_full_reg;
    logic        tx_full_reg;
    logic [63:0] rx_data_reg;
    logic [63:0] tx_data_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        rx_full_reg <= 1'b0;
        tx_full_reg <= 1'b0;
      end else begin
        if (rx_take && lv == VC)
          rx_full_reg <= 1'b1;
        else if (core_take && cv == VC)
          rx_full_reg <= 1'b0;
        if (core_put && cv == VC)
          tx_full_reg <= 1'b1;
        else if (tx_so && lv == VC)
          tx_full_reg <= 1'b0;
      end
    end

    // Data is left alone by reset; the full bits alone decide validity.
    always_ff @(posedge clk) begin
      if (rx_take && lv == VC)
        rx_data_reg <= rx_di;
      if (core_put && cv == VC)
        tx_data_reg <= core_di;
    end

    assign rx_full[gi] = rx_full_reg;
    assign tx_full[gi] = tx_full_reg;
    assign rx_data[gi] = rx_data_reg;
    assign tx_data[gi] = tx_data_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_count_reg <= '0;
      tx_count_reg <= '0;
    end else begin
      if (rx_take)
        rx_count_reg <= rx_count_reg + CNT_W'(1);
      if (tx_so)
        tx_count_reg <= tx_count_reg + CNT_W'(1);
    end
  end

  assign rx_count = rx_count_reg;
  assign tx_count = tx_count_reg;

endmodule

// File: tb/tb_cardinal_router_lport.sv
// Scoreboard bench for cardinal_router_lport: stimulus queues expected flits,
// a monitor pops them on every core/NIC delivery handshake.
module tb_cardinal_router_lport;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        polarity = 1'b0;
  logic        rx_si = 1'b0;
  logic        rx_ri;
  logic [63:0] rx_di = 64'h0;
  logic        tx_so;
  logic        tx_ro = 1'b0;
  logic [63:0] tx_do;
  logic        core_so;
  logic        core_ro = 1'b1;
  logic [63:0] core_do;
  logic        core_si = 1'b0;
  logic        core_ri;
  logic [63:0] core_di = 64'h0;
  logic [3:0]  rx_count;
  logic [3:0]  tx_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_core [$];
  logic [63:0] exp_tx [$];
  logic [3:0]  exp_rxc = 4'd0;
  logic [3:0]  exp_txc = 4'd0;

  cardinal_router_lport #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .rx_si(rx_si), .rx_ri(rx_ri), .rx_di(rx_di),
    .tx_so(tx_so), .tx_ro(tx_ro), .tx_do(tx_do),
    .core_so(core_so), .core_ro(core_ro), .core_do(core_do),
    .core_si(core_si), .core_ri(core_ri), .core_di(core_di),
    .rx_count(rx_count), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) polarity <= reset ? 1'b0 : ~polarity;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a delivery handshake completes at the next rising edge.
  always @(negedge clk) begin
    #2;
    if (core_so && core_ro) begin
      if (exp_core.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL core_do_unexpected: got %h expected none", core_do);
      end else begin
        chk("core_do", core_do, exp_core.pop_front());
      end
    end
    if (tx_so) begin
      if (exp_tx.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL tx_do_unexpected: got %h expected none", tx_do);
      end else begin
        chk("tx_do", tx_do, exp_tx.pop_front());
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    rx_si = 1'b0;
    core_si = 1'b0;
  endtask

  task automatic tick_pol(input logic p);
    tick();
    for (int i = 0; i < 3 && polarity != p; i++) tick();
    if (polarity != p) begin
      n_err++;
      $display("FAIL pol_sync: got %b expected %b", polarity, p);
    end
  endtask

  task automatic send_rx(input logic [63:0] d);
    rx_si = 1'b1;
    rx_di = d;
    exp_core.push_back(d);
    exp_rxc = exp_rxc + 4'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) tick();
    #1;
    chk("rst_rx_ri", rx_ri, 0);  chk("rst_core_ri", core_ri, 0);
    chk("rst_tx_do", tx_do, 0);
    tick(); reset = 1'b0; #1;
    chk("rx_ri", rx_ri, 1);    chk("core_ri", core_ri, 1);
    chk("core_so", core_so, 0); chk("tx_so", tx_so, 0);
    chk("tx_do", tx_do, 0);    chk("rx_count", rx_count, 0);
    chk("tx_count", tx_count, 0);

    // NIC to core, both VCs
    tick_pol(1); send_rx(64'hEEEE_EEEE_EEEE_EE00); #1 chk("rx_ri_p1", rx_ri, 1);
    tick(); #1 chk("core_so_vc0", core_so, 1); chk("rx_count_1", rx_count, exp_rxc);
    tick_pol(0); send_rx(64'hDDDD_DDDD_DDDD_DD11);
    tick(); #1 chk("core_so_vc1", core_so, 1); chk("rx_count_2", rx_count, exp_rxc);

    // RX backpressure
    tick_pol(0); core_ro = 1'b0; send_rx(64'hB10C_B10C_B10C_B10C);
    tick();
    tick(); #1 chk("bp_rx_ri", rx_ri, 0);
    rx_si = 1'b1; rx_di = 64'h1234_5678_9ABC_DEF0;
    tick(); #1 chk("bp_rx_count", rx_count, exp_rxc);
    core_ro = 1'b1;
    tick(); #1 chk("bp_rx_ri_back", rx_ri, 1); chk("bp_core_so", core_so, 0);

    // Core to NIC with blocking
    tick_pol(0); core_si = 1'b1; core_di = 64'h0BAD_F00D_0BAD_F00D;
    exp_tx.push_back(64'h0BAD_F00D_0BAD_F00D); #1 chk("tx_core_ri", core_ri, 1);
    for (int k = 0; k < 4; k++) begin
      tick(); #1 chk("blk_tx_so", tx_so, 0);
      if (polarity == 1'b0) chk("blk_core_ri", core_ri, 0);
    end
    tick(); tx_ro = 1'b1; exp_txc = exp_txc + 4'd1; #1 chk("tx_pulse", tx_so, 1);
    tick(); #1 chk("tx_after1", tx_so, 0); chk("tx_count_1", tx_count, exp_txc);
    tick(); #1 chk("tx_after2", tx_so, 0);

    // Simultaneous link and core activity
    tick_pol(0); tx_ro = 1'b0; core_ro = 1'b0;
    send_rx(64'hA1A1_A1A1_A1A1_A1A1);
    core_si = 1'b1; core_di = 64'hC0C0_C0C0_C0C0_C0C0; exp_tx.push_back(core_di);
    tick(); core_ro = 1'b1; tx_ro = 1'b1;
    send_rx(64'hA0A0_A0A0_A0A0_A0A0);
    core_si = 1'b1; core_di = 64'hC1C1_C1C1_C1C1_C1C1; exp_tx.push_back(core_di);
    exp_txc = exp_txc + 4'd1;
    #1 chk("sim_rx_ri", rx_ri, 1);     chk("sim_core_ri", core_ri, 1);
    chk("sim_core_so", core_so, 1);     chk("sim_tx_so", tx_so, 1);
    tick(); exp_txc = exp_txc + 4'd1;
    #1 chk("sim2_core_so", core_so, 1); chk("sim2_tx_so", tx_so, 1);
    tick(); #1 chk("sim_rx_count", rx_count, exp_rxc); chk("sim_tx_count", tx_count, exp_txc);
    chk("sim3_core_so", core_so, 0);    chk("sim3_tx_so", tx_so, 0);
    tx_ro = 1'b0;

    // Counter wrap with 4-bit counters
    reset = 1'b1; repeat (3) tick(); reset = 1'b0;
    exp_rxc = 4'd0; exp_txc = 4'd0;
    for (int i = 0; i < 17; i++) begin
      tick(); send_rx(64'h1000 + 64'(i)); #1 chk("wrap_rx_ri", rx_ri, 1);
    end
    tick(); #1 chk("wrap_rx_count", rx_count, 4'd1);

    // Reset with both rx buffers full
    tick_pol(0); core_ro = 1'b0;
    rx_si = 1'b1; rx_di = 64'hDEAD_0001_DEAD_0001;
    tick(); rx_si = 1'b1; rx_di = 64'hDEAD_0000_DEAD_0000;
    tick(); #1 chk("full_core_so", core_so, 1); chk("full_rx_ri", rx_ri, 0);
    tick(); reset = 1'b1; core_ro = 1'b1;
    #1 chk("mid_core_so", core_so, 0); chk("mid_rx_ri", rx_ri, 0);
    chk("mid_core_ri", core_ri, 0);     chk("mid_tx_so", tx_so, 0);
    tick(); reset = 1'b0;
    #1 chk("post_core_so0", core_so, 0); chk("post_rx_ri", rx_ri, 1);
    chk("post_rx_count", rx_count, 0);
    tick(); #1 chk("post_core_so1", core_so, 0);

    tick(); #3;
    chk("exp_core_left", 64'(exp_core.size()), 0);
    chk("exp_tx_left", 64'(exp_tx.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
